// File: rtl/rv32_alu_pkg.sv
// rv32_alu_pkg: shared types and helpers for the slice-serial ALU.
//   alu_op_e    : 3-bit operation codes presented on i_op
//   alu_state_e : control FSM states (IDLE, RUN, DONE)
//   is_arith()  : op uses the slice adder (ADD/SUB/SLT/SLTU)
//   inverts_b() : op subtracts, i.e. B is inverted and carry-in of slice 0 is 1
package rv32_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLT  = 3'd5,
    OP_SLTU = 3'd6,
    OP_RSV  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_arith(input alu_op_e op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic inverts_b(input alu_op_e op);
    logic r;
    case (op)
      OP_SUB, OP_SLT, OP_SLTU: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32_alu_slice.sv
// rv32_alu_slice: combinational SLICE_W-bit ALU slice, time-multiplexed by the FSM.
//   a, b     : operand slices
//   c_in     : carry into the slice LSB (chained carry register)
//   op       : operation
//   result   : slice result
//   c_out    : carry out of the slice MSB (0 for logic / unsupported ops)
//   c_msb_in : carry into the slice MSB, used for signed overflow
module rv32_alu_slice
  import rv32_alu_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  input  alu_op_e            op,
  output logic [SLICE_W-1:0] result,
  output logic               c_out,
  output logic               c_msb_in
);

  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W:0]   sum;

  // Shared adder; subtract-style ops see ~B and rely on the FSM's carry-in of 1
  always_comb begin
    b_eff = inverts_b(op) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, c_in};
  end

  // Result and carry selection per operation
  always_comb begin
    result   = '0;
    c_out    = 1'b0;
    c_msb_in = 1'b0;
    if (is_arith(op)) begin
      result   = sum[SLICE_W-1:0];
      c_out    = sum[SLICE_W];
      // a ^ b ^ sum at the MSB recovers the carry that entered that bit
      c_msb_in = a[SLICE_W-1] ^ b_eff[SLICE_W-1] ^ sum[SLICE_W-1];
    end else begin
      case (op)
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/rv32_alu_slice_fsm.sv
// rv32_alu_slice_fsm: multicycle integer ALU, one SLICE_W-bit slice per cycle.
//   i_clk, i_rst (async, active-high)
//   request : i_valid / o_ready, i_op, i_operand_one, i_operand_two
//   response: o_valid / i_ready, o_result, o_carry_out, o_overflow, o_zero, o_err
// Optional feature macro RV32_ALU_SLT_EN: enables ops 5 (SLT) and 6 (SLTU);
// without it those ops report o_err=1 with a zero result.
module rv32_alu_slice_fsm
  import rv32_alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_operand_one,
  input  logic [DATA_W-1:0] i_operand_two,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry_out,
  output logic              o_overflow,
  output logic              o_zero,
  output logic              o_err
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

`ifdef RV32_ALU_SLT_EN
  localparam logic SLT_EN = 1'b1;
`else
  localparam logic SLT_EN = 1'b0;
`endif

  if ((DATA_W % SLICE_W) != 0) begin : g_bad_slice_w
    $error("rv32_alu_slice_fsm: SLICE_W must divide DATA_W");
  end

  alu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  alu_op_e           op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;
  logic              ready_q, valid_q;

  logic [31:0]        base;
  logic [SLICE_W-1:0] slice_res;
  logic               slice_cout, slice_cmsb, msb_ovf, op_ok;

  assign base    = 32'(cnt_q) * 32'(SLICE_W);
  assign msb_ovf = slice_cmsb ^ slice_cout;
  assign op_ok   = (op_q != OP_RSV) && (SLT_EN || !((op_q == OP_SLT) || (op_q == OP_SLTU)));

  rv32_alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a        (a_q[base +: SLICE_W]),
    .b        (b_q[base +: SLICE_W]),
    .c_in     (carry_q),
    .op       (op_q),
    .result   (slice_res),
    .c_out    (slice_cout),
    .c_msb_in (slice_cmsb)
  );

  // State, operand capture, slice accumulation and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      ready_q  <= (state_d == IDLE);
      valid_q  <= (state_d == DONE);
    end
  end

  // Next-state logic, slice sequencing and flag evaluation at the last slice
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          op_d    = alu_op_e'(i_op);
          a_d     = i_operand_one;
          b_d     = i_operand_two;
          cnt_d   = '0;
          acc_d   = '0;
          // Subtraction is A + ~B + 1: the +1 enters as slice 0 carry-in
          carry_d = inverts_b(alu_op_e'(i_op));
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[base +: SLICE_W] = slice_res;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          if (!op_ok) begin
            err_d = 1'b1;
          end else begin
            case (op_q)
              OP_ADD, OP_SUB: begin
                result_d = acc_d;
                cout_d   = slice_cout;
                ovf_d    = msb_ovf;
              end
              OP_SLT: begin
                // signed less-than is N xor V of A-B
                result_d[0] = slice_res[SLICE_W-1] ^ msb_ovf;
                cout_d      = slice_cout;
                ovf_d       = msb_ovf;
              end
              OP_SLTU: begin
                // unsigned less-than is a borrow, i.e. no carry out
                result_d[0] = ~slice_cout;
                cout_d      = slice_cout;
                ovf_d       = msb_ovf;
              end
              default: result_d = acc_d;
            endcase
          end
          // Unsupported ops report every flag other than o_err as 0
          zero_d = ~err_d & (result_d == '0);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_carry_out = cout_q;
  assign o_overflow  = ovf_q;
  assign o_zero      = zero_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_rv32_alu_slice_fsm.sv
// Directed bench: three instances (SLICE_W 8, 4, 32) share one request/response
// stimulus; each is checked against hand-computed results at its own latency.
module tb_rv32_alu_slice_fsm;

  localparam int SW[3]  = '{8, 4, 32};
  localparam int LAT[3] = '{4, 8, 1};

  logic        clk = 1'b0;
  logic        rst, valid_i, ready_i;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        rdy [3];
  logic        vld [3];
  logic        cout[3];
  logic        ovf [3];
  logic        zero[3];
  logic        err [3];
  logic [31:0] res [3];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rv32_alu_slice_fsm #(.DATA_W(32), .SLICE_W(8)) u_dut_w8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_i), .o_ready(rdy[0]), .i_op(op),
    .i_operand_one(a), .i_operand_two(b), .o_valid(vld[0]), .i_ready(ready_i),
    .o_result(res[0]), .o_carry_out(cout[0]), .o_overflow(ovf[0]),
    .o_zero(zero[0]), .o_err(err[0]));

  rv32_alu_slice_fsm #(.DATA_W(32), .SLICE_W(4)) u_dut_w4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_i), .o_ready(rdy[1]), .i_op(op),
    .i_operand_one(a), .i_operand_two(b), .o_valid(vld[1]), .i_ready(ready_i),
    .o_result(res[1]), .o_carry_out(cout[1]), .o_overflow(ovf[1]),
    .o_zero(zero[1]), .o_err(err[1]));

  rv32_alu_slice_fsm #(.DATA_W(32), .SLICE_W(32)) u_dut_w32 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_i), .o_ready(rdy[2]), .i_op(op),
    .i_operand_one(a), .i_operand_two(b), .o_valid(vld[2]), .i_ready(ready_i),
    .o_result(res[2]), .o_carry_out(cout[2]), .o_overflow(ovf[2]),
    .o_zero(zero[2]), .o_err(err[2]));

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // flags packed as {carry_out, overflow, zero, err}
  function automatic logic [31:0] flags_of(input int i);
    return {28'd0, cout[i], ovf[i], zero[i], err[i]};
  endfunction

  // One op with i_ready high: valid must pulse exactly at each instance's latency
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_val($sformatf("%s rdy_pre w%0d", tag, SW[i]), {31'd0, rdy[i]}, 32'd1);
    op = o; a = x; b = y; valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; op = 3'd0; a = ~x; b = ~y;
    for (int k = 0; k <= 10; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (k == 0) chk_val($sformatf("%s rdy_run w%0d", tag, SW[i]), {31'd0, rdy[i]}, 32'd0);
        chk_val($sformatf("%s valid w%0d k%0d", tag, SW[i], k), {31'd0, vld[i]},
                {31'd0, (k == LAT[i])});
        if (k == LAT[i]) begin
          chk_val($sformatf("%s result w%0d", tag, SW[i]), res[i], er);
          chk_val($sformatf("%s flags w%0d", tag, SW[i]), flags_of(i), {28'd0, ef});
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_val($sformatf("reset ready w%0d", SW[i]), {31'd0, rdy[i]}, 32'd1);
      chk_val($sformatf("reset valid w%0d", SW[i]), {31'd0, vld[i]}, 32'd0);
      chk_val($sformatf("reset result w%0d", SW[i]), res[i], 32'd0);
      chk_val($sformatf("reset flags w%0d", SW[i]), flags_of(i), 32'h2);
    end

    run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010);
    run_op("add_ovf",  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0100);
    run_op("sub_neg",  3'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0000);
    run_op("sub_eq",   3'd1, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 4'b1010);
    run_op("sub_ovf",  3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100);
    run_op("or",       3'd3, 32'h0000_00F0, 32'h0F00_0000, 32'h0F00_00F0, 4'b0000);

    // Backpressure: i_ready low, i_valid and operands still toggling in RUN/DONE
    @(negedge clk);
    op = 3'd4; a = 32'hA5A5_0F0F; b = 32'hFFFF_FFFF; valid_i = 1'b1; ready_i = 1'b0;
    @(negedge clk);
    a = 32'h0; b = 32'h0;
    for (int k = 0; k <= 11; k++) begin
      for (int i = 0; i < 3; i++) begin
        chk_val($sformatf("bp valid w%0d k%0d", SW[i], k), {31'd0, vld[i]},
                {31'd0, (k >= LAT[i]) && (k <= 10)});
        chk_val($sformatf("bp ready w%0d k%0d", SW[i], k), {31'd0, rdy[i]}, {31'd0, (k == 11)});
        if ((k >= LAT[i]) && (k <= LAT[i] + 2)) begin
          chk_val($sformatf("bp result w%0d k%0d", SW[i], k), res[i], 32'h5A5A_F0F0);
          chk_val($sformatf("bp flags w%0d k%0d", SW[i], k), flags_of(i), 32'h0);
        end
      end
      if (k == 10) ready_i = 1'b1;
      if (k == 11) valid_i = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) chk_val($sformatf("bp no_accept w%0d", SW[i]), {31'd0, rdy[i]}, 32'd1);

    // Reset during RUN slice 2 of the 8-bit instance
    op = 3'd0; a = 32'h1234_5678; b = 32'h1111_1111; valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_val($sformatf("abort valid w%0d", SW[i]), {31'd0, vld[i]}, 32'd0);
      chk_val($sformatf("abort result w%0d", SW[i]), res[i], 32'd0);
      chk_val($sformatf("abort flags w%0d", SW[i]), flags_of(i), 32'h2);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_val($sformatf("abort ready w%0d", SW[i]), {31'd0, rdy[i]}, 32'd1);
      chk_val($sformatf("abort idle w%0d", SW[i]), {31'd0, vld[i]}, 32'd0);
    end
    run_op("and", 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0000);

    run_op("op7", 3'd7, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 4'b0001);
`ifdef RV32_ALU_SLT_EN
    run_op("slt",  3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b1000);
    run_op("sltu", 3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010);
`else
    run_op("slt",  3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0001);
    run_op("sltu", 3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
